// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 4-digit 7-segment scan driver.
// Latency: n/a (package); no backpressure.
package seg7_pkg;

  localparam int         NUM_DIGITS         = 4;
  localparam logic [3:0] DEFAULT_BLANK_CODE = 4'hF;
  localparam logic [3:0] ANODE_OFF          = 4'b1111;

  // Active-low one-hot anode select for digit i.
  function automatic logic [3:0] anode_onehot_n(input logic [1:0] i);
    return ~(4'b0001 << i);
  endfunction

endpackage

// File: rtl/seg7_refresh_timer.sv
// Slot prescaler and digit index counter for display scanning.
// Latency: free-running, outputs reflect current count; no backpressure.
module seg7_refresh_timer #(
  parameter  int REFRESH_DIV = 100000,
  localparam int PW          = $clog2(REFRESH_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [PW-1:0] prescaler,
  output logic [1:0]    idx,
  output logic          slot_end,
  output logic          frame_end
);

  assign slot_end  = (prescaler == PW'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (idx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      idx       <= '0;
    end else begin
      prescaler <= slot_end ? '0 : prescaler + PW'(1);
      if (slot_end) begin
        idx <= idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// 4-digit BCD scan driver: frame-aligned value updates, leading-zero blanking, anode guard.
// Latency: outputs registered 1 cycle after timer state; no backpressure, load is a one-shot strobe.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int         REFRESH_DIV  = 100000,
  parameter int         GUARD_CYCLES = 16,
  parameter logic [3:0] BLANK_CODE   = DEFAULT_BLANK_CODE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        lzb,
  input  logic        load,
  input  logic [15:0] value,
  output logic [3:0]  digit_o,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);

  logic [PW-1:0]         prescaler;
  logic [1:0]            idx;
  logic                  slot_end;
  logic                  frame_end;
  logic [15:0]           disp_reg;
  logic [15:0]           pend_reg;
  logic                  pend_vld;
  logic [NUM_DIGITS-1:0] blank;
  logic                  zero_above;
  logic                  in_guard;

  seg7_refresh_timer #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .prescaler (prescaler),
    .idx       (idx),
    .slot_end  (slot_end),
    .frame_end (frame_end)
  );

  // A load landing on the frame boundary wins over anything still pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_reg <= '0;
      pend_reg <= '0;
      pend_vld <= 1'b0;
    end else if (frame_end) begin
      if (load) begin
        disp_reg <= value;
      end else if (pend_vld) begin
        disp_reg <= pend_reg;
      end
      pend_vld <= 1'b0;
    end else if (load) begin
      pend_reg <= value;
      pend_vld <= 1'b1;
    end
  end

  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (disp_reg[4*i +: 4] == 4'h0);
      blank[i]   = lzb && zero_above;
    end
  end

  generate
    if (GUARD_CYCLES > 0) begin : g_guard
      assign in_guard = (prescaler < PW'(GUARD_CYCLES));
    end else begin : g_no_guard
      assign in_guard = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_o    <= BLANK_CODE;
      an         <= ANODE_OFF;
      frame_done <= 1'b0;
    end else begin
      digit_o    <= blank[idx] ? BLANK_CODE : disp_reg[{idx, 2'b00} +: 4];
      an         <= (!en || in_guard || blank[idx]) ? ANODE_OFF : anode_onehot_n(idx);
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboarded bench for seg7_scan_mux with REFRESH_DIV=8, GUARD_CYCLES=2.
module tb_seg7_scan_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        lzb = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  digit_o;
  logic [3:0]  an;
  logic        frame_done;

  int n_chk = 0;
  int n_err = 0;

  seg7_scan_mux #(
    .REFRESH_DIV  (8),
    .GUARD_CYCLES (2),
    .BLANK_CODE   (4'hF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .lzb        (lzb),
    .load       (load),
    .value      (value),
    .digit_o    (digit_o),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: expected {digit_o, an, frame_done} pushed at each clock edge.
  logic [8:0]  sb[$];
  int          m_pre;
  int          m_idx;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  logic        m_pvld;
  logic        m_blk;
  logic        m_fe;
  logic [3:0]  m_dig;
  logic [3:0]  m_an;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_pre = 0; m_idx = 0; m_disp = '0; m_pend = '0; m_pvld = 1'b0;
      sb.delete();
    end else begin
      m_fe  = (m_pre == 7) && (m_idx == 3);
      m_blk = lzb && (m_idx > 0) && ((m_disp >> (4 * m_idx)) == 16'h0);
      m_dig = m_blk ? 4'hF : m_disp[4*m_idx +: 4];
      m_an  = (!en || m_pre < 2 || m_blk) ? 4'hF : ~(4'b0001 << m_idx);
      sb.push_back({m_dig, m_an, m_fe});
      if (m_fe) begin
        if (load) m_disp = value;
        else if (m_pvld) m_disp = m_pend;
        m_pvld = 1'b0;
      end else if (load) begin
        m_pend = value;
        m_pvld = 1'b1;
      end
      if (m_pre == 7) begin
        m_pre = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_pre++;
      end
    end
  end

  logic [8:0] sb_exp;
  logic [3:0] prev_dig = 4'hF;
  logic       watch_one = 1'b0;
  logic       seen_one = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!rst && sb.size() > 0) begin
      sb_exp = sb.pop_front();
      chk("out", 16'({digit_o, an, frame_done}), 16'(sb_exp));
      chk("an_onehot", 16'($countones(~an) <= 1), 16'd1);
      if (digit_o != prev_dig) chk("digit_change_guard", 16'(an), 16'hF);
    end
    if (watch_one && an != 4'hF && digit_o == 4'h1) seen_one = 1'b1;
    prev_dig = digit_o;
  end

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_fd();
    logic found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      @(negedge clk);
      found = frame_done;
    end
    chk("fd_seen", 16'(found), 16'd1);
  endtask

  // Checks one full frame from a frame_done negedge; dig/anp hold slot s in bits [4s+3:4s].
  task automatic show_frame(input logic [15:0] dig, input logic [15:0] anp);
    int fd = 0;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (frame_done && !(s == 3 && c == 7)) fd++;
        if (c == 1) chk($sformatf("guard_s%0d", s), 16'(an), 16'hF);
        if (c == 4) begin
          chk($sformatf("digit_s%0d", s), 16'(digit_o), 16'(dig[4*s +: 4]));
          chk($sformatf("an_s%0d", s), 16'(an), 16'(anp[4*s +: 4]));
        end
      end
    end
    chk("fd_period", 16'(frame_done), 16'd1);
    chk("fd_extra", 16'(fd), 16'd0);
  endtask

  localparam logic [15:0] AN_ALL = 16'b0111_1011_1101_1110;

  initial begin
    int cnt;
    logic found;
    repeat (3) @(negedge clk);
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_digit", 16'(digit_o), 16'hF);
    chk("rst_fd", 16'(frame_done), 16'd0);
    chk("rst_disp", dut.disp_reg, 16'h0);
    chk("rst_pend_vld", 16'(dut.pend_vld), 16'd0);
    rst = 1'b0;

    // Basic scan of 1234
    @(negedge clk);
    do_load(16'h1234);
    wait_fd();
    show_frame(16'h1234, AN_ALL);

    // Leading-zero blanking
    lzb = 1'b1;
    do_load(16'h0050);
    wait_fd();
    show_frame(16'hFF50, 16'hFFDE);
    do_load(16'h0000);
    wait_fd();
    show_frame(16'hFFF0, 16'hFFFE);

    // Last pending load wins; 1111 never shown
    lzb = 1'b0;
    watch_one = 1'b1;
    repeat (4) @(negedge clk);
    do_load(16'h1111);
    @(negedge clk);
    do_load(16'h2222);
    wait_fd();
    show_frame(16'h2222, AN_ALL);
    watch_one = 1'b0;
    chk("never_1111", 16'(seen_one), 16'd0);

    // Load on the frame_end cycle while 5555 pending
    do_load(16'h5555);
    repeat (30) @(negedge clk);
    do_load(16'h9876);
    chk("fe_align", 16'(frame_done), 16'd1);
    chk("pend_vld_cleared", 16'(dut.pend_vld), 16'd0);
    chk("disp_9876", dut.disp_reg, 16'h9876);
    show_frame(16'h9876, AN_ALL);

    // Display disable mid-frame
    repeat (4) @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("en_off_an", 16'(an), 16'hF);
    end
    en = 1'b1;
    cnt = 0;
    found = 1'b0;
    while (!found && cnt < 64) begin
      @(negedge clk);
      cnt++;
      found = frame_done;
    end
    chk("fd_phase", 16'(cnt), 16'd8);
    show_frame(16'h9876, AN_ALL);

    // Async reset in slot 2
    repeat (20) @(negedge clk);
    chk("pre_rst_an", 16'(an), 16'b1011);
    #1 rst = 1'b1;
    #1;
    chk("async_an", 16'(an), 16'hF);
    chk("async_digit", 16'(digit_o), 16'hF);
    chk("async_fd", 16'(frame_done), 16'd0);
    @(negedge clk);
    chk("rst2_disp", dut.disp_reg, 16'h0);
    chk("rst2_pend_vld", 16'(dut.pend_vld), 16'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_g0", 16'(an), 16'hF);
    @(negedge clk);
    chk("post_rst_g1", 16'(an), 16'hF);
    @(negedge clk);
    chk("post_rst_an", 16'(an), 16'b1110);
    chk("post_rst_digit", 16'(digit_o), 16'h0);
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
